// File: rtl/blk2s_seq_ctrl.sv
// BLAKE2s block sequencer: splits a request into 64-byte compression jobs and
// folds each engine result into the chaining value. Keyed mode: BLK2S_SEQ_KEYED_EN.
module blk2s_seq_ctrl #(
  parameter int MAX_BLOCKS = 4,
  parameter int KEY_SIZE   = 32,
  localparam int LW        = $clog2(MAX_BLOCKS*64+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [MAX_BLOCKS*512-1:0] in_msg,
  input  logic [LW-1:0]             in_len,
  input  logic [KEY_SIZE*8-1:0]     in_key,
  input  logic [5:0]                in_klen,
  input  logic [5:0]                in_olen,
  output logic                      cmp_vld,
  output logic [255:0]              cmp_h,
  output logic [511:0]              cmp_m,
  output logic [63:0]               cmp_t,
  output logic [63:0]               cmp_f,
  input  logic                      cmp_rdy,
  input  logic                      cmp_done,
  input  logic [255:0]              cmp_hi,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [255:0]              out_h,
  output logic [5:0]                out_olen
);

  localparam int MSG_BYTES = MAX_BLOCKS*64;
  localparam int BW        = $clog2(MAX_BLOCKS+2);
  localparam int MIW       = $clog2(MAX_BLOCKS*512);
  localparam logic [255:0] IV =
    256'h5BE0CD19_1F83D9AB_9B05688C_510E527F_A54FF53A_3C6EF372_BB67AE85_6A09E667;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             blk_q, blk_d, nblk_q, nblk_d, blk_nxt;
  logic [255:0]              h_q, h_d;
  logic [MAX_BLOCKS*512-1:0] msg_q, msg_d;
  logic [LW-1:0]             len_q, len_d, len_c;
  logic [5:0]                klen_q, klen_d, klen_c;
  logic [5:0]                olen_q, olen_d, olen_c;
  logic [BW-1:0]             nblk_c;
  logic                      kb, last;
  logic [BW-1:0]             mi;
  int                        blk_bytes;

`ifdef BLK2S_SEQ_KEYED_EN
  localparam int KIW = $clog2(KEY_SIZE*8);
  logic [KEY_SIZE*8-1:0] key_q, key_d;
`else
  logic unused_key;
  assign unused_key = ^{in_key, in_klen};
`endif

  always_comb begin
    olen_c = (in_olen == 6'd0 || in_olen > 6'd32) ? 6'd32 : in_olen;
    len_c  = (int'(in_len) > MSG_BYTES) ? LW'(MSG_BYTES) : in_len;
`ifdef BLK2S_SEQ_KEYED_EN
    klen_c = (int'(in_klen) > KEY_SIZE) ? 6'(KEY_SIZE) : in_klen;
`else
    klen_c = 6'd0;
`endif
    nblk_c = BW'(int'(klen_c != 6'd0) + (int'(len_c) + 63) / 64);
    if (nblk_c == '0) nblk_c = BW'(1);
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    nblk_d  = nblk_q;
    h_d     = h_q;
    msg_d   = msg_q;
    len_d   = len_q;
    klen_d  = klen_q;
    olen_d  = olen_q;
`ifdef BLK2S_SEQ_KEYED_EN
    key_d   = key_q;
`endif
    blk_nxt = blk_q + BW'(1);
    in_rdy  = 1'b0;
    cmp_vld = 1'b0;
    out_vld = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          msg_d   = in_msg;
          len_d   = len_c;
          klen_d  = klen_c;
          olen_d  = olen_c;
          nblk_d  = nblk_c;
          blk_d   = '0;
          h_d     = IV ^ {224'b0, 8'd1, 8'd1, 2'b00, klen_c, 2'b00, olen_c};
`ifdef BLK2S_SEQ_KEYED_EN
          key_d   = in_key;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmp_vld = 1'b1;
        if (cmp_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cmp_done) begin
          h_d     = h_q ^ cmp_hi;
          blk_d   = blk_nxt;
          state_d = (blk_nxt < nblk_q) ? S_ISSUE : S_DONE;
        end
      end
      S_DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Block 0 is the key block when keyed; message blocks follow, zero past len.
  always_comb begin
    kb        = (klen_q != 6'd0);
    mi        = blk_q - BW'(kb);
    last      = (blk_q == nblk_q - BW'(1));
    cmp_m     = '0;
    cmp_t     = 64'd0;
    blk_bytes = 0;
    if (kb && blk_q == '0) begin
`ifdef BLK2S_SEQ_KEYED_EN
      for (int j = 0; j < 64; j++) begin
        if (j < int'(klen_q)) cmp_m[j*8 +: 8] = key_q[KIW'(j*8) +: 8];
      end
`endif
      cmp_t = 64'd64;
    end else begin
      for (int j = 0; j < 64; j++) begin
        if (int'(mi)*64 + j < int'(len_q))
          cmp_m[j*8 +: 8] = msg_q[MIW'((int'(mi)*64 + j)*8) +: 8];
      end
      blk_bytes = (int'(mi) + 1) * 64;
      if (blk_bytes > int'(len_q)) blk_bytes = int'(len_q);
      cmp_t = 64'(blk_bytes) + (kb ? 64'd64 : 64'd0);
    end
    cmp_f = last ? 64'h0000_0000_FFFF_FFFF : 64'd0;
    cmp_h = h_q;
  end

  assign out_h    = h_q;
  assign out_olen = olen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
    nblk_q <= nblk_d;
    h_q    <= h_d;
    msg_q  <= msg_d;
    len_q  <= len_d;
    klen_q <= klen_d;
    olen_q <= olen_d;
`ifdef BLK2S_SEQ_KEYED_EN
    key_q  <= key_d;
`endif
  end

endmodule

// File: tb/tb_blk2s_seq_ctrl.sv
// Scoreboard bench for blk2s_seq_ctrl: expected jobs/digests are queued at
// request time and popped by a monitor on each engine or result handshake.
module tb_blk2s_seq_ctrl;

   localparam int MAX_BLOCKS = 4;
   localparam int KEY_SIZE   = 32;
   localparam int LW         = $clog2(MAX_BLOCKS*64+1);
   localparam logic [255:0] IV =
      256'h5BE0CD19_1F83D9AB_9B05688C_510E527F_A54FF53A_3C6EF372_BB67AE85_6A09E667;

   logic                      clk, rst;
   logic                      in_vld, in_rdy;
   logic [MAX_BLOCKS*512-1:0] in_msg;
   logic [LW-1:0]             in_len;
   logic [KEY_SIZE*8-1:0]     in_key;
   logic [5:0]                in_klen, in_olen;
   logic                      cmp_vld, cmp_rdy, cmp_done;
   logic [255:0]              cmp_h, cmp_hi;
   logic [511:0]              cmp_m;
   logic [63:0]               cmp_t, cmp_f;
   logic                      out_vld, out_rdy;
   logic [255:0]              out_h;
   logic [5:0]                out_olen;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [255:0] h;
      logic [511:0] m;
      logic [63:0]  t;
      logic [63:0]  f;
   } job_t;

   typedef struct {
      logic [255:0] h;
      logic [5:0]   olen;
   } res_t;

   job_t exp_jobs[$];
   res_t exp_res[$];
   job_t mon_job;
   res_t mon_res;

   blk2s_seq_ctrl #(.MAX_BLOCKS(MAX_BLOCKS), .KEY_SIZE(KEY_SIZE)) dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_msg(in_msg), .in_len(in_len),
      .in_key(in_key), .in_klen(in_klen), .in_olen(in_olen),
      .cmp_vld(cmp_vld), .cmp_h(cmp_h), .cmp_m(cmp_m), .cmp_t(cmp_t), .cmp_f(cmp_f),
      .cmp_rdy(cmp_rdy), .cmp_done(cmp_done), .cmp_hi(cmp_hi),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_h(out_h), .out_olen(out_olen)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a bounded wait is ever defeated
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Message, key and engine-result patterns, all derived from the test id
   function automatic logic [7:0] pat(input int tid, input int idx);
      return {1'b1, 7'(idx + tid*13)};
   endfunction

   function automatic logic [7:0] keyb(input int tid, input int j);
      return {2'b01, 6'(j + tid)};
   endfunction

   function automatic logic [255:0] hiFor(input int tid, input int k);
      logic [255:0] r;
      for (int w = 0; w < 8; w++)
         r[w*32 +: 32] = 32'(tid*16777619 + k*65537 + w*286331153) ^ 32'h0BADF00D;
      return r;
   endfunction

   function automatic logic [511:0] blockExp(input int tid, input int k, input int len_e, input int klen_e);
      logic [511:0] b;
      int kb;
      int idx;
      b  = '0;
      kb = (klen_e != 0) ? 1 : 0;
      for (int j = 0; j < 64; j++) begin
         if (kb == 1 && k == 0) begin
            if (j < klen_e) b[j*8 +: 8] = keyb(tid, j);
         end else begin
            idx = (k - kb)*64 + j;
            if (idx < len_e) b[j*8 +: 8] = pat(tid, idx);
         end
      end
      return b;
   endfunction

   // Monitor: pops one expectation per engine or result handshake
   always @(negedge clk) begin
      if (!rst && cmp_vld && cmp_rdy) begin
         if (exp_jobs.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL job_unexpected: got job t=%0h expected none", cmp_t);
         end else begin
            mon_job = exp_jobs.pop_front();
            checkOutput("job_h", cmp_h, mon_job.h);
            checkOutput("job_m", cmp_m, mon_job.m);
            checkOutput("job_t", cmp_t, mon_job.t);
            checkOutput("job_f", cmp_f, mon_job.f);
         end
      end
      if (!rst && out_vld && out_rdy) begin
         if (exp_res.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL result_unexpected: got digest %0h expected none", out_h);
         end else begin
            mon_res = exp_res.pop_front();
            checkOutput("digest_h", out_h, mon_res.h);
            checkOutput("digest_olen", out_olen, mon_res.olen);
         end
      end
   end

   // Drive request fields and queue the expected jobs and digest
   task automatic applyStimulus(input int tid, input int len, input int klen, input int olen, output int nblk);
      int olen_e, len_e, klen_e, kb, mi, endb;
      logic [255:0] h;
      job_t j;
      res_t r;
      for (int i = 0; i < MAX_BLOCKS*64; i++) in_msg[i*8 +: 8] = pat(tid, i);
      for (int i = 0; i < KEY_SIZE; i++) in_key[i*8 +: 8] = keyb(tid, i);
      in_len  = LW'(len);
      in_klen = 6'(klen);
      in_olen = 6'(olen);
      olen_e  = (olen == 0 || olen > 32) ? 32 : olen;
      len_e   = (len > MAX_BLOCKS*64) ? MAX_BLOCKS*64 : len;
`ifdef BLK2S_SEQ_KEYED_EN
      klen_e  = (klen > KEY_SIZE) ? KEY_SIZE : klen;
`else
      klen_e  = 0;
`endif
      kb   = (klen_e != 0) ? 1 : 0;
      nblk = kb + (len_e + 63) / 64;
      if (nblk == 0) nblk = 1;
      h = IV ^ {224'b0, 8'd1, 8'd1, 8'(klen_e), 8'(olen_e)};
      for (int k = 0; k < nblk; k++) begin
         j.h = h;
         j.m = blockExp(tid, k, len_e, klen_e);
         if (kb == 1 && k == 0) begin
            j.t = 64'd64;
         end else begin
            mi   = k - kb;
            endb = (mi + 1) * 64;
            if (endb > len_e) endb = len_e;
            j.t  = 64'(endb + kb*64);
         end
         j.f = (k == nblk - 1) ? 64'h0000_0000_FFFF_FFFF : 64'd0;
         exp_jobs.push_back(j);
         h = h ^ hiFor(tid, k);
      end
      r.h    = h;
      r.olen = 6'(olen_e);
      exp_res.push_back(r);
   endtask

   task automatic acceptReq();
      int cnt;
      cnt    = 0;
      in_vld = 1'b1;
      while (!in_rdy) begin
         @(negedge clk);
         cnt++;
         if (cnt > 20) begin
            checkOutput("accept_timeout", 0, 1);
            in_vld = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1 in_vld = 1'b0;
      @(negedge clk);
      checkOutput("cmp_vld_latency", cmp_vld, 1);
   endtask

   task automatic serveJobs(input int tid, input int nblk, input int rdy_delay, input bit spurious);
      int cnt;
      for (int k = 0; k < nblk; k++) begin
         cnt = 0;
         while (!cmp_vld) begin
            @(negedge clk);
            cnt++;
            if (cnt > 20) begin
               checkOutput("cmp_vld_timeout", 0, 1);
               return;
            end
         end
         if (k == 0) begin
            for (int d = 0; d < rdy_delay; d++) begin
               @(posedge clk);
               #1;
               cmp_done = spurious && (d == 1);
               cmp_hi   = ~hiFor(tid, k);
               @(negedge clk);
               checkOutput("issue_hold_vld", cmp_vld, 1);
               if (exp_jobs.size() > 0) begin
                  checkOutput("issue_hold_m", cmp_m, exp_jobs[0].m);
                  checkOutput("issue_hold_h", cmp_h, exp_jobs[0].h);
               end
            end
         end
         @(posedge clk);
         #1 cmp_done = 1'b0;
         cmp_rdy = 1'b1;
         @(posedge clk);
         #1 cmp_rdy = 1'b0;
         @(posedge clk);
         #1 cmp_done = 1'b1;
         cmp_hi = hiFor(tid, k);
         @(posedge clk);
         #1 cmp_done = 1'b0;
         @(negedge clk);
         if (k == nblk - 1) checkOutput("out_vld_latency", out_vld, 1);
         else               checkOutput("cmp_vld_reissue", cmp_vld, 1);
      end
   endtask

   task automatic drainResult(input int out_delay, input bit spurious, input bit overlap);
      int cnt;
      cnt = 0;
      while (!out_vld) begin
         @(negedge clk);
         cnt++;
         if (cnt > 20) begin
            checkOutput("out_vld_timeout", 0, 1);
            return;
         end
      end
      for (int d = 0; d < out_delay; d++) begin
         @(posedge clk);
         #1;
         cmp_done = spurious && (d == 0);
         cmp_hi   = 256'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4;
         @(negedge clk);
         checkOutput("done_hold_vld", out_vld, 1);
         checkOutput("done_in_rdy", in_rdy, 0);
         if (exp_res.size() > 0) checkOutput("done_hold_h", out_h, exp_res[0].h);
      end
      @(posedge clk);
      #1 cmp_done = 1'b0;
      out_rdy = 1'b1;
      if (overlap) in_vld = 1'b1;
      @(posedge clk);
      #1 out_rdy = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_rdy", in_rdy, 1);
      checkOutput("out_vld_drop", out_vld, 0);
      if (overlap) checkOutput("no_early_accept", cmp_vld, 0);
   endtask

   initial begin
      int nb, nb2;
      rst      = 1'b1;
      in_vld   = 1'b0;
      in_msg   = '0;
      in_len   = '0;
      in_key   = '0;
      in_klen  = '0;
      in_olen  = '0;
      cmp_rdy  = 1'b0;
      cmp_done = 1'b0;
      cmp_hi   = '0;
      out_rdy  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_in_rdy", in_rdy, 1);
      checkOutput("reset_cmp_vld", cmp_vld, 0);
      checkOutput("reset_out_vld", out_vld, 0);

      $display("[TB] empty unkeyed message");
      applyStimulus(1, 0, 0, 32, nb);
      acceptReq();
      checkOutput("param_word0", cmp_h[31:0], 32'h6B08E647);
      serveJobs(1, nb, 0, 1'b0);
      drainResult(0, 1'b0, 1'b0);

      $display("[TB] len=100 with engine stall, spurious done and output stall");
      applyStimulus(2, 100, 0, 32, nb);
      acceptReq();
      serveJobs(2, nb, 5, 1'b1);
      drainResult(3, 1'b1, 1'b0);

      $display("[TB] olen=0 len=300 clamps");
      applyStimulus(3, 300, 0, 0, nb);
      acceptReq();
      serveJobs(3, nb, 0, 1'b0);
      drainResult(0, 1'b0, 1'b0);

      $display("[TB] klen=32 len=64 olen=16");
      applyStimulus(4, 64, 32, 16, nb);
      acceptReq();
      serveJobs(4, nb, 2, 1'b0);
      drainResult(1, 1'b0, 1'b0);

      $display("[TB] klen=5 len=0 olen=40");
      applyStimulus(5, 0, 5, 40, nb);
      acceptReq();
      serveJobs(5, nb, 0, 1'b0);
      drainResult(0, 1'b0, 1'b0);

      $display("[TB] request raised during the DONE handshake");
      applyStimulus(6, 64, 0, 20, nb);
      acceptReq();
      serveJobs(6, nb, 0, 1'b0);
      applyStimulus(7, 65, 0, 33, nb2);
      drainResult(0, 1'b0, 1'b1);
      acceptReq();
      serveJobs(7, nb2, 0, 1'b0);
      drainResult(0, 1'b0, 1'b0);

      $display("[TB] reset while waiting on the engine");
      applyStimulus(8, 100, 0, 32, nb);
      acceptReq();
      @(posedge clk);
      #1 cmp_rdy = 1'b1;
      @(posedge clk);
      #1 cmp_rdy = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_jobs.delete();
      exp_res.delete();
      @(negedge clk);
      checkOutput("abort_in_rdy", in_rdy, 1);
      checkOutput("abort_cmp_vld", cmp_vld, 0);
      checkOutput("abort_out_vld", out_vld, 0);
      @(posedge clk);
      #1 cmp_done = 1'b1;
      cmp_hi = hiFor(8, 0);
      @(posedge clk);
      #1 cmp_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("abort_quiet_out", out_vld, 0);
         checkOutput("abort_quiet_cmp", cmp_vld, 0);
      end

      $display("[TB] one-byte request after abort");
      applyStimulus(9, 1, 0, 1, nb);
      acceptReq();
      serveJobs(9, nb, 0, 1'b0);
      drainResult(0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      checkOutput("jobs_drained", 512'(exp_jobs.size()), 0);
      checkOutput("results_drained", 512'(exp_res.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
